sar_data_receiver: RTL
======================

Name: sar_data_receiver

Overview:
Receiving end of the SAR ADC serial result stream. Watches COMP_CLK and DIGITAL_OUT from the SAR logic and samples one bit per SAR conversion step, MSB first. Assembles BIT_ADC-bit words and buffers them in a small FIFO. Presents words to the digital back end over a valid/ready handshake, with sticky overflow and stall-timeout error flags.

Parameters:
BIT_ADC, 8, result word width and bits per conversion; MSB first.
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
TIMEOUT_CYC, 16, CLK cycles without a COMP_CLK falling edge before a partial word is abandoned.
WCNT_W, 16, width of the accepted-word counter.

Ports:
CLK  in  1  system clock (48 MHz PLL clock, same domain as the SAR logic).
RST  in  1  synchronous, active-high reset.
EN  in  1  acquisition enable.
COMP_CLK  in  1  comparator clock from the SAR logic; same domain as CLK, no synchroniser.
DIGITAL_OUT  in  1  latched 1-bit A/D result from the SAR logic.
DATA  out  BIT_ADC  FIFO head word.
DATA_VALID  out  1  FIFO non-empty.
DATA_READY  in  1  consumer accepts DATA when DATA_VALID && DATA_READY.
OVERFLOW  out  1  sticky: a completed word was dropped because the FIFO was full.
TIMEOUT_ERR  out  1  sticky: a partial word was abandoned on stall.
CLR_FLAGS  in  1  clears OVERFLOW and TIMEOUT_ERR.
WORD_CNT  out  WCNT_W  count of words pushed into the FIFO; wraps.

Behaviour:
- Reset (RST=1 at posedge CLK): DATA=0, DATA_VALID=0, OVERFLOW=0, TIMEOUT_ERR=0, WORD_CNT=0.
  - Reset also clears FIFO pointers and count, shift register, bit_cnt, idle counter and comp_clk_d. FSM goes to IDLE.
  - Reset mid-word discards the partial word.
- Edge detect: comp_clk_d <= COMP_CLK every cycle, including in IDLE.
  - fall = comp_clk_d & ~COMP_CLK.
  - DIGITAL_OUT is stable at the fall; it was updated while COMP_CLK was high.
- FSM state IDLE: entered when EN=0.
  - Clears bit_cnt and the idle counter; any partial word is discarded without a flag.
  - Transitions to ACQ when EN=1.
- FSM state ACQ, on fall:
  - shift <= {shift[BIT_ADC-2:0], DIGITAL_OUT}.
  - bit_cnt increments; idle counter clears.
  - When bit_cnt==BIT_ADC-1: word {shift[BIT_ADC-2:0], DIGITAL_OUT} is pushed the same cycle, and bit_cnt <= 0.
- FSM state ACQ, with no fall:
  - Idle counter increments, saturating at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC with bit_cnt!=0: TIMEOUT_ERR <= 1, bit_cnt <= 0, idle counter <= 0.
  - No error while bit_cnt==0, i.e. a between-words stall is legal.
- ACQ → IDLE when EN=0; takes effect the next cycle. A fall in the same cycle that EN drops is ignored.
- Framing: bit 0 after reset or after leaving IDLE is the MSB. The SAR logic and this block must leave reset together.
- FIFO:
  - Latency: push at edge N gives DATA_VALID=1 and DATA valid after edge N.
  - Pop happens on DATA_VALID && DATA_READY.
  - Push when full with a pop in the same cycle is accepted and the count is unchanged.
  - Push when full without a pop drops the word, sets OVERFLOW <= 1 and leaves WORD_CNT unchanged.
  - Pop when empty is ignored.
  - DATA holds stable while DATA_VALID=1 and DATA_READY=0.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- WORD_CNT increments on every accepted push and wraps at 2^WCNT_W.
- CLR_FLAGS coinciding with a new error event: the set wins and the flag stays 1.

Decomposition:
- Shared package sar_pkg holds:
  - BIT_ADC = 8, the single source also used by the SAR logic;
  - the 48 MHz / 8 MHz step length constant (6);
  - the receiver state enum {IDLE, ACQ}.
- One sub-module, sar_rx_fifo: synchronous FIFO with push, pop, full, empty and data head, parameterised on width and depth.
- The shifter, edge detect, watchdog and flags stay in the top level.

Test Plan:
- Bit-true SAR model: 6-cycle step, COMP_CLK high for 3 cycles, bits 1,0,1,1,0,0,1,0, DATA_READY=1.
  - Required: DATA=8'hB2 with DATA_VALID=1 for one cycle, 1 cycle after the 8th fall; WORD_CNT=1.
- Overflow: DATA_READY=0, stream 5 words 8'h01..8'h05.
  - Required: OVERFLOW=1 after the 5th word; draining yields 01,02,03,04 then DATA_VALID=0; WORD_CNT=4.
- Stall: 3 bits, then COMP_CLK held low for 16 cycles, then word 8'hA5.
  - Required: TIMEOUT_ERR=1; next word read is exactly 8'hA5.
  - Then CLR_FLAGS=1 for one cycle; required: TIMEOUT_ERR=0.
- Full + simultaneous pop and push: fill 4 entries, hold DATA_READY=1 in the cycle the 5th word completes.
  - Required: no OVERFLOW; drain order 1,2,3,4,5.
- RST=1 for one cycle after 5 bits of a word, then a fresh word 8'h3C.
  - Required: all outputs 0 right after reset; the next word read is 8'h3C, not merged with the earlier bits.
- EN dropped mid-word for 10 cycles, then re-enabled, then word 8'hFF.
  - Required: no flags; only 8'hFF is delivered.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC result path.
//   BIT_ADC  : result word width, also used by the SAR conversion logic
//   STEP_CYC : CLK cycles per SAR conversion step (48 MHz / 8 MHz)
//   rx_state_e : receiver acquisition states
package sar_pkg;

  localparam int BIT_ADC  = 8;
  localparam int STEP_CYC = 6;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sar_rx_fifo.sv
// Synchronous FIFO buffering assembled SAR words.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write data_i (accepted when not full, or full with a pop)
//   pop_i        : remove head entry (ignored when empty)
//   data_o       : head entry, zero while empty
//   full_o, empty_o : occupancy status
module sar_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sar_data_receiver.sv
// Receiver for the SAR ADC serial result stream. Samples DIGITAL_OUT on each
// COMP_CLK falling edge (MSB first), assembles BIT_ADC-bit words, buffers them
// in a FIFO and hands them out over valid/ready.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   en_i            : acquisition enable
//   comp_clk_i      : comparator clock (same clock domain)
//   digital_out_i   : comparator result bit
//   data_o, data_valid_o, data_ready_i : output word handshake
//   overflow_o      : sticky, completed word dropped on full FIFO
//   timeout_err_o   : sticky, partial word abandoned on stall
//   clr_flags_i     : clears both sticky flags
//   word_cnt_o      : count of words accepted into the FIFO (wraps)
module sar_data_receiver #(
  parameter int BIT_ADC     = sar_pkg::BIT_ADC,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int WCNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               comp_clk_i,
  input  logic               digital_out_i,
  output logic [BIT_ADC-1:0] data_o,
  output logic               data_valid_o,
  input  logic               data_ready_i,
  output logic               overflow_o,
  output logic               timeout_err_o,
  input  logic               clr_flags_i,
  output logic [WCNT_W-1:0]  word_cnt_o
);

  import sar_pkg::*;

  localparam int BW = $clog2(BIT_ADC);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  rx_state_e          state_q, state_d;
  logic               sample_en;
  logic               comp_clk_q, fall;
  logic [BIT_ADC-1:0] shift_q, shift_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  logic               overflow_q, timeout_q;
  logic [WCNT_W-1:0]  word_cnt_q;
  logic               push, pop, push_acc, overflow_evt, timeout_evt;
  logic               fifo_full, fifo_empty;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = ACQ;
      ACQ:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. A fall in the cycle EN drops is already ignored here.
  always_comb begin
    sample_en = (state_q == ACQ) && en_i;
  end

  assign fall = comp_clk_q & ~comp_clk_i;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    push        = 1'b0;
    timeout_evt = 1'b0;
    if (!sample_en) begin
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else if (fall) begin
      shift_d    = {shift_q[BIT_ADC-2:0], digital_out_i};
      idle_cnt_d = '0;
      if (bit_cnt_q == BW'(BIT_ADC - 1)) begin
        bit_cnt_d = '0;
        push      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else begin
      if (idle_cnt_q != IW'(TIMEOUT_CYC)) idle_cnt_d = idle_cnt_q + 1'b1;
      // Stalls between words are legal; only a partial word times out.
      if (idle_cnt_d == IW'(TIMEOUT_CYC) && bit_cnt_q != '0) begin
        timeout_evt = 1'b1;
        bit_cnt_d   = '0;
        idle_cnt_d  = '0;
      end
    end
  end

  assign pop          = data_valid_o && data_ready_i;
  assign push_acc     = push && (!fifo_full || pop);
  assign overflow_evt = push && fifo_full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      comp_clk_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      comp_clk_q <= comp_clk_i;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      // New error events take priority over a simultaneous clear.
      if (overflow_evt)     overflow_q <= 1'b1;
      else if (clr_flags_i) overflow_q <= 1'b0;
      if (timeout_evt)      timeout_q  <= 1'b1;
      else if (clr_flags_i) timeout_q  <= 1'b0;
      if (push_acc) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  sar_rx_fifo #(
    .WIDTH (BIT_ADC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (shift_d),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_valid_o  = !fifo_empty;
  assign overflow_o    = overflow_q;
  assign timeout_err_o = timeout_q;
  assign word_cnt_o    = word_cnt_q;

endmodule
